mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and RAM signals of the instruction/data memory arbiter.
// The slave side is the arbiter, the master side is the requesters plus the RAM.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  i_IReq;
   logic [31:0]           i_IAddr;
   logic                  o_IAck;
   logic [31:0]           o_IData;

   logic                  i_DReq;
   logic                  i_DWrite;
   logic [31:0]           i_DAddr;
   logic [31:0]           i_DWData;
   logic [2:0]            i_DWidth;
   logic                  i_DSignExt;
   logic                  o_DAck;
   logic [31:0]           o_DRData;
   logic                  o_DErr;

   logic                  o_RamEn;
   logic [3:0]            o_RamWe;
   logic [ADDR_WIDTH-1:0] o_RamAddr;
   logic [31:0]           o_RamWData;
   logic [31:0]           i_RamRData;

   modport slave (
      input  i_IReq, i_IAddr,
      output o_IAck, o_IData,
      input  i_DReq, i_DWrite, i_DAddr, i_DWData, i_DWidth, i_DSignExt,
      output o_DAck, o_DRData, o_DErr,
      output o_RamEn, o_RamWe, o_RamAddr, o_RamWData,
      input  i_RamRData
   );

   modport master (
      output i_IReq, i_IAddr,
      input  o_IAck, o_IData,
      output i_DReq, i_DWrite, i_DAddr, i_DWData, i_DWidth, i_DSignExt,
      input  o_DAck, o_DRData, o_DErr,
      input  o_RamEn, o_RamWe, o_RamAddr, o_RamWData,
      output i_RamRData
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one single-port RAM.
// Data has priority; a starvation counter forces a fetch grant after repeated denials.
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 10,
   parameter int STARVE_LIMIT = 4
) (
   input logic          i_CLK,
   input logic          i_RSTn,
   mem_arbiter_if.slave bus
);
   localparam int         CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [2:0] W_BYTE = 3'd1;
   localparam logic [2:0] W_HALF = 3'd2;
   localparam logic [2:0] W_WORD = 3'd3;

   typedef enum logic [2:0] {IDLE, I_ACC, I_WAIT, D_ACC, D_WAIT, D_ERR} state_t;

   state_t                 state, state_nx;
   logic [CNT_W-1:0]       starve_cnt;
   logic                   starve_full;
   logic                   fetch_win, data_win, d_legal;

   logic                   ram_en_p0,    ram_en_p1;
   logic [3:0]             ram_we_p0,    ram_we_p1;
   logic [ADDR_WIDTH-1:0]  ram_addr_p0,  ram_addr_p1;
   logic [31:0]            ram_wdata_p0, ram_wdata_p1;

   logic [1:0]             d_off_p1;
   logic [2:0]             d_width_p1;
   logic                   d_sext_p1, d_write_p1;

   logic                   unused_addr_bits;

   function automatic logic is_legal(input logic [2:0] width, input logic [1:0] off);
      case (width)
         W_BYTE:  is_legal = 1'b1;
         W_HALF:  is_legal = ~off[0];
         W_WORD:  is_legal = (off == 2'b00);
         default: is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_lanes(input logic [2:0] width, input logic [1:0] off);
      case (width)
         W_BYTE:  store_lanes = 4'b0001 << off;
         W_HALF:  store_lanes = off[1] ? 4'b1100 : 4'b0011;
         default: store_lanes = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] width, input logic [31:0] wd);
      case (width)
         W_BYTE:  store_data = {4{wd[7:0]}};
         W_HALF:  store_data = {2{wd[15:0]}};
         default: store_data = wd;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] width, input logic [1:0] off,
                                                input logic sext, input logic [31:0] rdata);
      logic [31:0]        sh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] ext;
      sh  = rdata >> {off, 3'b000};
      b   = sh[7:0];
      h   = sh[15:0];
      ext = '0;
      case (width)
         W_BYTE: begin
            if (sext) ext = b;
            else      ext = {24'h0, sh[7:0]};
         end
         W_HALF: begin
            if (sext) ext = h;
            else      ext = {16'h0, sh[15:0]};
         end
         default: ext = rdata;
      endcase
      load_extract = ext;
   endfunction

   assign starve_full      = (starve_cnt == CNT_W'(STARVE_LIMIT));
   assign d_legal          = is_legal(bus.i_DWidth, bus.i_DAddr[1:0]);
   assign unused_addr_bits = ^{bus.i_IAddr[31:ADDR_WIDTH+2], bus.i_IAddr[1:0],
                               bus.i_DAddr[31:ADDR_WIDTH+2]};

   always_comb begin
      state_nx     = state;
      fetch_win    = 1'b0;
      data_win     = 1'b0;
      ram_en_p0    = 1'b0;
      ram_we_p0    = '0;
      ram_addr_p0  = '0;
      ram_wdata_p0 = '0;
      case (state)
         IDLE: begin
            fetch_win = bus.i_IReq && (!bus.i_DReq || starve_full);
            data_win  = bus.i_DReq && !fetch_win;
            if (fetch_win) begin
               state_nx    = I_ACC;
               ram_en_p0   = 1'b1;
               ram_addr_p0 = bus.i_IAddr[ADDR_WIDTH+1:2];
            end else if (data_win) begin
               if (!d_legal) begin
                  state_nx = D_ERR;
               end else begin
                  state_nx    = D_ACC;
                  ram_en_p0   = 1'b1;
                  ram_addr_p0 = bus.i_DAddr[ADDR_WIDTH+1:2];
                  if (bus.i_DWrite) begin
                     ram_we_p0    = store_lanes(bus.i_DWidth, bus.i_DAddr[1:0]);
                     ram_wdata_p0 = store_data(bus.i_DWidth, bus.i_DWData);
                  end
               end
            end
         end
         I_ACC:   state_nx = I_WAIT;
         D_ACC:   state_nx = D_WAIT;
         default: state_nx = IDLE;
      endcase
   end

   // p0 -> p1: grant decision registered into the RAM strobe and FSM state
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state        <= IDLE;
         starve_cnt   <= '0;
         ram_en_p1    <= 1'b0;
         ram_we_p1    <= '0;
         ram_addr_p1  <= '0;
         ram_wdata_p1 <= '0;
      end else begin
         state        <= state_nx;
         ram_en_p1    <= ram_en_p0;
         ram_we_p1    <= ram_we_p0;
         ram_addr_p1  <= ram_addr_p0;
         ram_wdata_p1 <= ram_wdata_p0;
         if (!bus.i_IReq || fetch_win)
            starve_cnt <= '0;
         else if (data_win && !starve_full)
            starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // Lane and extension info for the load result, captured at the data grant
   always_ff @(posedge i_CLK) begin
      if (data_win) begin
         d_off_p1   <= bus.i_DAddr[1:0];
         d_width_p1 <= bus.i_DWidth;
         d_sext_p1  <= bus.i_DSignExt;
         d_write_p1 <= bus.i_DWrite;
      end
   end

   assign bus.o_RamEn    = ram_en_p1;
   assign bus.o_RamWe    = ram_we_p1;
   assign bus.o_RamAddr  = ram_addr_p1;
   assign bus.o_RamWData = ram_wdata_p1;

   // p1 -> p2: RAM read data returns in the WAIT state and is acked combinationally
   assign bus.o_IAck   = (state == I_WAIT);
   assign bus.o_IData  = (state == I_WAIT) ? bus.i_RamRData : '0;
   assign bus.o_DAck   = (state == D_WAIT) || (state == D_ERR);
   assign bus.o_DErr   = (state == D_ERR);
   assign bus.o_DRData = (state == D_WAIT && !d_write_p1)
                         ? load_extract(d_width_p1, d_off_p1, d_sext_p1, bus.i_RamRData) : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level model
// with its own RAM image and per-cycle output expectations.
module tb_mem_arbiter;
   localparam int AW = 10;
   localparam int SL = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
   mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
      .i_CLK (clk),
      .i_RSTn(rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic          ram_en;
      logic [3:0]    we;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic          iack;
      logic [31:0]   idata;
      logic          dack;
      logic          derr;
      logic [31:0]   drdata;
      logic          st;
      logic [AW-1:0] st_addr;
      logic [3:0]    st_we;
      logic [31:0]   st_data;
   } exp_t;

   logic [31:0] mem     [1024];
   logic [31:0] ref_mem [1024];
   logic        load_img;

   exp_t        e1, e2;
   int          t, idle_cyc, starve;
   logic        in_reset, rnd, hold_i, hold_d;
   int          n_chk, n_bad, en_cnt, ord_n;
   logic [9:0]  ord_obs;

   // RAM: one-cycle read latency, byte-lane writes
   always @(posedge clk) begin
      if (load_img) begin
         for (int k = 0; k < 1024; k++) mem[k] <= ref_mem[k];
      end else if (bus.o_RamEn) begin
         bus.i_RamRData <= mem[bus.o_RamAddr];
         for (int j = 0; j < 4; j++)
            if (bus.o_RamWe[j]) mem[bus.o_RamAddr][8*j +: 8] <= bus.o_RamWData[8*j +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%h want=%h cycle=%0d", tag, got, want, t);
      end
   endtask

   task automatic set_d(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] w, input logic se);
      bus.i_DReq     = 1'b1;
      bus.i_DWrite   = wr;
      bus.i_DAddr    = a;
      bus.i_DWData   = wd;
      bus.i_DWidth   = w;
      bus.i_DSignExt = se;
   endtask

   task automatic check_cycle();
      chk("ram_en",    32'(bus.o_RamEn),    32'(e1.ram_en));
      chk("ram_we",    32'(bus.o_RamWe),    32'(e1.we));
      chk("ram_addr",  32'(bus.o_RamAddr),  32'(e1.addr));
      chk("ram_wdata", bus.o_RamWData,      e1.wdata);
      chk("iack",      32'(bus.o_IAck),     32'(e1.iack));
      chk("idata",     bus.o_IData,         e1.idata);
      chk("dack",      32'(bus.o_DAck),     32'(e1.dack));
      chk("derr",      32'(bus.o_DErr),     32'(e1.derr));
      chk("drdata",    bus.o_DRData,        e1.drdata);
      if (bus.o_RamEn) en_cnt++;
      if ((bus.o_IAck || bus.o_DAck) && ord_n < 10) begin
         ord_obs = {ord_obs[8:0], bus.o_IAck};
         ord_n++;
      end
      if (e1.st)
         for (int j = 0; j < 4; j++)
            if (e1.st_we[j]) ref_mem[e1.st_addr][8*j +: 8] = e1.st_data[8*j +: 8];
      if (e1.iack && !hold_i) bus.i_IReq = 1'b0;
      if (e1.dack && !hold_d) bus.i_DReq = 1'b0;
      e1 = e2;
      e2 = '0;
   endtask

   task automatic model_step();
      logic          fw, legal;
      int            w, nb, off;
      logic [AW-1:0] a;
      logic [31:0]   v, m, wd;
      if (!bus.i_IReq || in_reset) starve = 0;
      if (in_reset) begin
         idle_cyc = t + 1;
      end else if (t == idle_cyc) begin
         if (!bus.i_IReq && !bus.i_DReq) begin
            idle_cyc = t + 1;
         end else begin
            fw = bus.i_IReq && (!bus.i_DReq || starve == SL);
            if (fw) begin
               starve    = 0;
               a         = bus.i_IAddr[AW+1:2];
               e1.ram_en = 1'b1;
               e1.addr   = a;
               e2.iack   = 1'b1;
               e2.idata  = ref_mem[a];
               idle_cyc  = t + 3;
            end else begin
               if (bus.i_IReq && starve < SL) starve++;
               w     = int'(bus.i_DWidth);
               off   = int'(bus.i_DAddr[1:0]);
               a     = bus.i_DAddr[AW+1:2];
               wd    = bus.i_DWData;
               legal = (w >= 1 && w <= 3) && ((off % (1 << (w - 1))) == 0);
               if (!legal) begin
                  e1.dack  = 1'b1;
                  e1.derr  = 1'b1;
                  idle_cyc = t + 2;
               end else begin
                  nb        = 1 << (w - 1);
                  e1.ram_en = 1'b1;
                  e1.addr   = a;
                  e2.dack   = 1'b1;
                  idle_cyc  = t + 3;
                  if (bus.i_DWrite) begin
                     for (int j = 0; j < 4; j++) e1.wdata[8*j +: 8] = wd[8*(j % nb) +: 8];
                     for (int k = 0; k < nb; k++) begin
                        e1.we[off+k]             = 1'b1;
                        e2.st_data[8*(off+k) +: 8] = wd[8*k +: 8];
                     end
                     e2.st      = 1'b1;
                     e2.st_addr = a;
                     e2.st_we   = e1.we;
                  end else begin
                     v = ref_mem[a] >> (8 * off);
                     m = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
                     v = v & m;
                     if (bus.i_DSignExt && v[8*nb-1]) v = v | ~m;
                     e2.drdata = v;
                  end
               end
            end
         end
      end
      t++;
   endtask

   task automatic rand_req();
      logic [2:0] w;
      if (!bus.i_IReq && $urandom_range(2) == 0) begin
         bus.i_IReq  = 1'b1;
         bus.i_IAddr = $urandom;
      end
      if (!bus.i_DReq && $urandom_range(2) == 0) begin
         w = ($urandom_range(4) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(3, 1));
         set_d(1'($urandom_range(1)), $urandom, $urandom, w, 1'($urandom_range(1)));
      end
   endtask

   task automatic cyc_a();
      @(negedge clk);
      check_cycle();
   endtask

   task automatic step();
      cyc_a();
      if (rnd) rand_req();
      model_step();
   endtask

   int en0, nw;

   initial begin
      n_chk = 0; n_bad = 0; en_cnt = 0; ord_n = 10; ord_obs = '0;
      t = 0; idle_cyc = 0; starve = 0;
      e1 = '0; e2 = '0;
      rnd = 1'b0; hold_i = 1'b0; hold_d = 1'b0;
      rst_n = 1'b0; in_reset = 1'b1;
      bus.i_IReq = 1'b1; bus.i_IAddr = 32'h104;
      set_d(1'b1, 32'h0, 32'h0, 3'd3, 1'b0);
      for (int k = 0; k < 1024; k++) ref_mem[k] = $urandom;
      ref_mem[65] = 32'hDEAD_BEEF;
      load_img = 1'b1;

      // reset held with both requests raised: everything stays quiet
      cyc_a(); load_img = 1'b0; model_step();
      repeat (3) step();
      cyc_a();
      rst_n = 1'b1; in_reset = 1'b0;
      bus.i_IReq = 1'b0; bus.i_DReq = 1'b0;
      model_step();
      step();

      // fetch of word 65
      cyc_a(); bus.i_IReq = 1'b1; bus.i_IAddr = 32'h104; model_step();
      cyc_a(); chk("t42_addr", 32'(bus.o_RamAddr), 32'd65); model_step();
      cyc_a(); chk("t42_iack", 32'(bus.o_IAck), 32'd1);
      chk("t42_idata", bus.o_IData, 32'hDEAD_BEEF); model_step();
      repeat (2) step();

      // byte store then signed byte load
      cyc_a(); set_d(1'b1, 32'h203, 32'hAB, 3'd1, 1'b0); model_step();
      cyc_a(); chk("t43_addr", 32'(bus.o_RamAddr), 32'd128);
      chk("t43_we", 32'(bus.o_RamWe), 32'h8);
      chk("t43_wdata", bus.o_RamWData, 32'hABAB_ABAB); model_step();
      repeat (2) step();
      cyc_a(); set_d(1'b0, 32'h203, 32'h0, 3'd1, 1'b1); model_step();
      step();
      cyc_a(); chk("t43_load", bus.o_DRData, 32'hFFFF_FFAB); model_step();
      repeat (2) step();

      // both requests held high: fetch every fifth grant
      cyc_a();
      hold_i = 1'b1; hold_d = 1'b1; ord_n = 0; ord_obs = '0;
      bus.i_IReq = 1'b1; bus.i_IAddr = 32'h80;
      set_d(1'b0, 32'h40, 32'h0, 3'd3, 1'b0);
      model_step();
      repeat (31) step();
      hold_i = 1'b0; hold_d = 1'b0;
      repeat (8) step();
      chk("t44_order", 32'(ord_obs), 32'h021);

      // illegal accesses: misaligned word and bad width
      repeat (2) step();
      en0 = en_cnt;
      cyc_a(); set_d(1'b0, 32'h6, 32'h0, 3'd3, 1'b0); model_step();
      cyc_a(); chk("t45_ack", 32'(bus.o_DAck), 32'd1);
      chk("t45_err", 32'(bus.o_DErr), 32'd1); model_step();
      step();
      cyc_a(); set_d(1'b0, 32'h10, 32'h0, 3'd4, 1'b0); model_step();
      cyc_a(); chk("t45w_ack", 32'(bus.o_DAck), 32'd1);
      chk("t45w_err", 32'(bus.o_DErr), 32'd1); model_step();
      repeat (2) step();
      chk("t45_noram", 32'(en_cnt - en0), 32'd0);

      // reset during the access cycle of a store
      repeat (2) step();
      cyc_a(); set_d(1'b1, 32'h310, 32'h1234_5678, 3'd3, 1'b0); model_step();
      cyc_a();
      rst_n = 1'b0;
      #1;
      chk("t46_en", 32'(bus.o_RamEn), 32'd0);
      chk("t46_dack", 32'(bus.o_DAck), 32'd0);
      bus.i_DReq = 1'b0; in_reset = 1'b1; e1 = '0; e2 = '0;
      model_step();
      repeat (2) step();
      cyc_a(); rst_n = 1'b1; in_reset = 1'b0; model_step();
      repeat (3) step();
      cyc_a(); set_d(1'b0, 32'h310, 32'h0, 3'd3, 1'b0); model_step();
      repeat (4) step();

      // random traffic
      rnd = 1'b1;
      repeat (1500) step();
      rnd = 1'b0;
      repeat (10) step();

      nw = 0;
      for (int k = 0; k < 1024; k++) if (mem[k] !== ref_mem[k]) nw++;
      chk("mem_image", 32'(nw), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
